// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART frame transmit sequencer:
//                FSM state encoding, CRC-16/CCITT-FALSE constants and the
//                bytes-per-frame helper.
//  Config      : UART_FRAME_CRC_EN - frame carries two trailing CRC bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Number of bytes put on the wire for an nbytes-long payload.
    function automatic int frame_bytes(input int nbytes);
`ifdef UART_FRAME_CRC_EN
        return nbytes + 2;
`else
        return nbytes;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc16_byte.sv
// ============================================================================
//  Module      : crc16_byte
//  Description : Combinational single-byte CRC-16 update, MSB first,
//                polynomial CRC16_POLY, no reflection.
//  Ports       : i_crc  [15:0] - running CRC before this byte
//                i_data [7:0]  - byte to fold in
//                o_crc  [15:0] - running CRC after this byte
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc16_byte
    import uart_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;

    always_comb begin
        // The byte is aligned to the top of the register, then shifted out
        // one bit at a time.
        w_crc = i_crc ^ {i_data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (w_crc[15]) begin
                w_crc = {w_crc[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                w_crc = {w_crc[14:0], 1'b0};
            end
        end
        o_crc = w_crc;
    end

endmodule

`default_nettype wire

// File: rtl/uart_frame_tx_seq.sv
// ============================================================================
//  Module      : uart_frame_tx_seq
//  Description : Captures an NBYTES-wide frame in one cycle and feeds it to a
//                byte-level UART transmitter, byte 0 first, paced by tx_done,
//                with an optional inter-byte gap and a tx_done watchdog.
//  Config      : UART_FRAME_CRC_EN - append CRC-16/CCITT-FALSE (high byte
//                first) computed over the payload; requires DATA_W == 8.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                start             - frame request (IDLE only)
//                frame_data        - payload, byte k at [k*DATA_W +: DATA_W]
//                tx_done           - UART byte-complete pulse
//                tx_data/tx_start  - byte and launch pulse to the UART
//                busy, byte_idx    - activity and index of byte in flight
//                frame_done        - pulse when the frame completes
//                timeout_err       - pulse when the watchdog aborts a frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_tx_seq
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NBYTES      = 16,
    parameter int GAP_CYCLES  = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NBYTES*DATA_W-1:0]      frame_data,
    input  logic                          tx_done,
    output logic [DATA_W-1:0]             tx_data,
    output logic                          tx_start,
    output logic                          busy,
    output logic [$clog2(NBYTES+2)-1:0]   byte_idx,
    output logic                          frame_done,
    output logic                          timeout_err
);

    localparam int IDX_W = $clog2(NBYTES + 2);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(frame_bytes(NBYTES) - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WD_W-1:0]  c_WD_LAST    = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t                     state_q, state_d;
    logic [NBYTES*DATA_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [WD_W-1:0]            wd_q, wd_d;

    logic [DATA_W-1:0]          w_payload_byte;
    logic [DATA_W-1:0]          w_cur_byte;
    logic                       w_wd_expire;

    // Payload byte selected by the current index; zero past the payload.
    always_comb begin
        w_payload_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_payload_byte = buf_q[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef UART_FRAME_CRC_EN
    localparam logic [IDX_W-1:0] c_CRC_HI_IDX = IDX_W'(NBYTES);
    localparam logic [IDX_W-1:0] c_CRC_LO_IDX = IDX_W'(NBYTES + 1);

    logic [15:0] crc_q, crc_d;
    logic [15:0] w_crc_next;

    if (DATA_W != 8) begin : g_crc_width_check
        $error("UART_FRAME_CRC_EN requires DATA_W == 8");
    end

    crc16_byte u_crc16_byte (
        .i_crc  (crc_q),
        .i_data (w_payload_byte[7:0]),
        .o_crc  (w_crc_next)
    );

    always_comb begin
        w_cur_byte = w_payload_byte;
        if (idx_q == c_CRC_HI_IDX) begin
            w_cur_byte = crc_q[15:8];
        end else if (idx_q == c_CRC_LO_IDX) begin
            w_cur_byte = crc_q[7:0];
        end
    end

    // Payload bytes are folded in as they are issued, so the CRC is final
    // by the time the first CRC byte is selected.
    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_IDLE && start) begin
            crc_d = CRC16_INIT;
        end else if (state_q == ST_SEND && idx_q < c_CRC_HI_IDX) begin
            crc_d = w_crc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign w_cur_byte = w_payload_byte;
`endif

    assign w_wd_expire = (TIMEOUT_CYC > 0) && (wd_q == c_WD_LAST);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        wd_d        = wd_q;
        tx_start    = 1'b0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    buf_d   = frame_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_start = 1'b1;
                wd_d     = '0;
                state_d  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // tx_done takes priority over a watchdog expiry in the same cycle.
                if (tx_done) begin
                    if (idx_q == c_LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        gap_d   = '0;
                        state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_SEND;
                    end
                end else if (w_wd_expire) begin
                    timeout_err = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_IDLE;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign byte_idx = idx_q;
    assign tx_data  = (state_q == ST_IDLE) ? '0 : w_cur_byte;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_tx_seq.sv
// ============================================================================
//  Module      : tb_uart_frame_tx_seq
//  Description : Self-checking bench for uart_frame_tx_seq. A reference model
//                derives expected tx_start timing, byte sequence, busy,
//                byte_idx, frame_done and timeout_err from the frame contents
//                and the handshake the bench plays back.
//  Config      : UART_FRAME_CRC_EN - nine-byte payload plus two CRC bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_tx_seq;

`ifdef UART_FRAME_CRC_EN
    localparam int NB  = 9;
    localparam int NBT = NB + 2;
`else
    localparam int NB  = 4;
    localparam int NBT = NB;
`endif
    localparam int DW    = 8;
    localparam int GAP   = 3;
    localparam int TO    = 16;
    localparam int IDX_W = $clog2(NB + 2);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [NB*DW-1:0]     frame_data;
    logic                 tx_done;
    logic [DW-1:0]        tx_data;
    logic                 tx_start;
    logic                 busy;
    logic [IDX_W-1:0]     byte_idx;
    logic                 frame_done;
    logic                 timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int m_idx       = 0;   // model of byte_idx while idle

    always #5 clk = ~clk;

    uart_frame_tx_seq #(
        .DATA_W      (DW),
        .NBYTES      (NB),
        .GAP_CYCLES  (GAP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .frame_data  (frame_data),
        .tx_done     (tx_done),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .byte_idx    (byte_idx),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    function automatic logic [NB*DW-1:0] rand_frame();
        logic [NB*DW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = 8'($urandom);
        return r;
    endfunction

`ifdef UART_FRAME_CRC_EN
    // Bit-serial CRC-16/CCITT-FALSE over the payload, byte 0 first.
    function automatic logic [15:0] ref_crc(input logic [NB*DW-1:0] f);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int b = 0; b < NB; b++) begin
            for (int i = 7; i >= 0; i--) begin
                fb = r[15] ^ f[b*DW + i];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction
`endif

    // Plays one frame through the DUT. Cycle 0 is the start cycle; the UART
    // answers each byte after lat cycles (random 1..TO when lat <= 0),
    // except byte 'withhold', which never gets tx_done.
    task automatic run_frame(input logic [NB*DW-1:0] f, input bit pre_started,
                             input int lat_fix, input int withhold, input bit spurious,
                             input bit chain, input logic [NB*DW-1:0] next_f,
                             input string name);
        logic [7:0] bq [NBT];
        int exp_start, k, done_cyc, last_done, exp_fd, exp_to, end_c, lat, ki;
        bit exp_busy, in_gap, finished;
        for (int b = 0; b < NB; b++) bq[b] = f[b*DW +: DW];
`ifdef UART_FRAME_CRC_EN
        begin
            logic [15:0] cr;
            cr = ref_crc(f);
            bq[NB]   = cr[15:8];
            bq[NB+1] = cr[7:0];
        end
`endif
        if (!pre_started) begin
            @(posedge clk); #1;
            start = 1'b1; frame_data = f; tx_done = 1'b0;
            #1;
        end
        exp_start = 1; k = 0; done_cyc = -1; last_done = -1;
        exp_fd = -1; exp_to = -1; end_c = -1; finished = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            in_gap  = (GAP > 0) && (last_done > 0) && (c > last_done) && (c < exp_start) && (k < NBT);
            start   = spurious && (c % 3 == 2) && (end_c < 0 || c <= end_c);
            frame_data = rand_frame();
            tx_done = (c == done_cyc) || (spurious && in_gap);
            if (chain && c == end_c + 1) begin
                start = 1'b1; frame_data = next_f;
            end
            #1;
            exp_busy = (end_c < 0) || (c <= end_c);
            ki = (k < NBT) ? k : NBT - 1;
            vectors++;
            if (tx_start !== (c == exp_start)) begin
                miscompares++;
                $display("FAIL %s tx_start: got %b want %b (cycle %0d)", name, tx_start, c == exp_start, c);
            end
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL %s busy: got %b want %b (cycle %0d)", name, busy, exp_busy, c);
            end
            vectors++;
            if (frame_done !== (c == exp_fd)) begin
                miscompares++;
                $display("FAIL %s frame_done: got %b want %b (cycle %0d)", name, frame_done, c == exp_fd, c);
            end
            vectors++;
            if (timeout_err !== (c == exp_to)) begin
                miscompares++;
                $display("FAIL %s timeout_err: got %b want %b (cycle %0d)", name, timeout_err, c == exp_to, c);
            end
            if (exp_busy) begin
                vectors++;
                if (byte_idx !== IDX_W'(ki)) begin
                    miscompares++;
                    $display("FAIL %s byte_idx: got %0d want %0d (cycle %0d)", name, byte_idx, ki, c);
                end
                vectors++;
                if (tx_data !== bq[ki]) begin
                    miscompares++;
                    $display("FAIL %s tx_data: got %h want %h (cycle %0d)", name, tx_data, bq[ki], c);
                end
            end else begin
                vectors++;
                if (byte_idx !== IDX_W'((exp_fd >= 0) ? NBT - 1 : 0)) begin
                    miscompares++;
                    $display("FAIL %s idle byte_idx: got %0d want %0d", name, byte_idx, (exp_fd >= 0) ? NBT - 1 : 0);
                end
            end
            // Model update for the next cycle.
            if (c == exp_start) begin
                if (k == withhold) begin
                    exp_to = c + TO;
                    end_c  = exp_to;
                end else begin
                    lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, TO);
                    done_cyc = c + lat;
                end
            end
            if (c == done_cyc) begin
                k++;
                last_done = c;
                if (k == NBT) begin
                    exp_fd = c + 1;
                    end_c  = c + 1;
                end else begin
                    exp_start = c + 1 + GAP;
                end
            end
            if (end_c >= 0 && c == end_c + 1) begin
                m_idx = (exp_fd >= 0) ? NBT - 1 : 0;
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL %s completion: got no frame end want end within 600 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; tx_done = 1'b0; frame_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            vectors++;
            if ({tx_start, busy, frame_done, timeout_err} !== 4'b0 || tx_data !== '0 || byte_idx !== '0) begin
                miscompares++;
                $display("FAIL reset outputs: got start=%b busy=%b fd=%b to=%b data=%h idx=%0d want all 0",
                         tx_start, busy, frame_done, timeout_err, tx_data, byte_idx);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_idx = 0;
    endtask

    // tx_done pulses while idle must not move anything.
    task automatic test_idle_handshake();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            tx_done = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (busy !== 1'b0 || tx_start !== 1'b0 || frame_done !== 1'b0 || byte_idx !== IDX_W'(m_idx)) begin
                miscompares++;
                $display("FAIL idle_handshake: got busy=%b start=%b fd=%b idx=%0d want 0 0 0 %0d",
                         busy, tx_start, frame_done, byte_idx, m_idx);
            end
        end
        tx_done = 1'b0;
    endtask

    task automatic test_byte_order();
        logic [NB*DW-1:0] f;
        for (int b = 0; b < NB; b++) f[b*DW +: DW] = 8'(8'hAA + 8'h11 * b);
        run_frame(f, 1'b0, 10, -1, 1'b0, 1'b0, '0, "byte_order");
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 6; n++) begin
            run_frame(rand_frame(), 1'b0, 0, -1, 1'b1, 1'b0, '0, "random");
        end
        // tx_done coinciding with the watchdog limit must win.
        run_frame(rand_frame(), 1'b0, TO, -1, 1'b0, 1'b0, '0, "done_at_limit");
    endtask

    task automatic test_back_to_back();
        logic [NB*DW-1:0] fa, fb;
        fa = rand_frame();
        fb = rand_frame();
        run_frame(fa, 1'b0, 0, -1, 1'b0, 1'b1, fb, "b2b_first");
        run_frame(fb, 1'b1, 0, -1, 1'b0, 1'b0, '0, "b2b_second");
    endtask

    task automatic test_watchdog();
        run_frame(rand_frame(), 1'b0, 0, 2, 1'b0, 1'b0, '0, "watchdog");
        test_idle_handshake();
    endtask

    task automatic test_reset_mid_frame();
        int nstarts, dcyc, rc;
        bit hit;
        nstarts = 0; dcyc = -1; rc = -1; hit = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; frame_data = rand_frame(); tx_done = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            tx_done = (c == dcyc);
            reset   = (c == rc);
            #1;
            if (c == rc + 1 && rc > 0) begin
                vectors++;
                if ({tx_start, busy, frame_done, timeout_err} !== 4'b0 || tx_data !== '0 || byte_idx !== '0) begin
                    miscompares++;
                    $display("FAIL reset_mid_frame: got start=%b busy=%b fd=%b to=%b data=%h idx=%0d want all 0",
                             tx_start, busy, frame_done, timeout_err, tx_data, byte_idx);
                end
                hit = 1'b1;
            end else if (rc > 0 && c > rc + 1) begin
                vectors++;
                if (busy !== 1'b0 || frame_done !== 1'b0 || timeout_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_aftermath: got busy=%b fd=%b to=%b want 0 0 0", busy, frame_done, timeout_err);
                end
                if (c > rc + 25) break;
            end
            if (tx_start && rc < 0) begin
                nstarts++;
                if (nstarts == 1) dcyc = c + 3;
                else rc = c + 1;
            end
        end
        reset = 1'b0;
        m_idx = 0;
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL reset_mid_frame: got no second tx_start want one within 200 cycles");
        end
    endtask

`ifdef UART_FRAME_CRC_EN
    task automatic test_crc();
        logic [NB*DW-1:0] f;
        for (int b = 0; b < NB; b++) f[b*DW +: DW] = 8'(8'h31 + b);
        run_frame(f, 1'b0, 5, -1, 1'b0, 1'b0, '0, "crc_123456789");
    endtask
`endif

    initial begin
        test_reset();
        test_idle_handshake();
        test_byte_order();
        test_idle_handshake();
        test_random_frames();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_frame();
`ifdef UART_FRAME_CRC_EN
        test_crc();
`endif
        test_idle_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got simulation still running want finished");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire

// File: doc/uart_frame_tx_seq.md
Name: uart_frame_tx_seq

Overview:
- Parametrised frame transmit sequencer. Captures an NBYTES-wide parallel frame in one cycle and drives a byte-level UART transmitter one byte at a time.
- Paces bytes by the UART's tx_done handshake, with an optional inter-byte gap and a tx_done watchdog.
- Sits between the AES/CRC datapath and uart_tx. Replaces the fixed controller-plus-separate-PISO arrangement with a single block that owns the buffer and the byte counter.

Parameters:
- DATA_W, 8: bits per UART byte.
- NBYTES, 16: payload bytes per frame; must be >= 1.
- GAP_CYCLES, 0: idle cycles between a tx_done and the next tx_start; 0 means back-to-back.
- TIMEOUT_CYC, 4096: maximum cycles spent waiting for tx_done before aborting; 0 disables the watchdog.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- start, input, 1: frame request; sampled only in IDLE.
- frame_data, input, NBYTES*DATA_W: payload. Byte k is frame_data[k*DATA_W +: DATA_W]; byte 0 is sent first.
- tx_done, input, 1: one-cycle pulse from the UART when the current byte has finished.
- tx_data, output, DATA_W: byte to transmit. Valid from the tx_start cycle and held until tx_done.
- tx_start, output, 1: one-cycle pulse that launches a UART byte.
- busy, output, 1: high in every state except IDLE.
- byte_idx, output, $clog2(NBYTES+2): index of the byte currently in flight.
- frame_done, output, 1: one-cycle pulse when the frame completes.
- timeout_err, output, 1: one-cycle pulse when the frame is aborted by the watchdog.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state goes to IDLE.
  - All outputs are 0, including tx_data, byte_idx and both counters.
  - Reset asserted mid-frame aborts the frame immediately, with no frame_done and no timeout_err.
- FSM states: IDLE, SEND, WAIT_DONE, GAP, DONE.
- IDLE:
  - If start=1, latch frame_data into the internal buffer, set byte_idx=0, and go to SEND.
  - start is ignored in every other state.
  - The frame is captured on the start cycle, so frame_data may change afterwards.
- SEND: tx_start=1 for exactly one cycle, tx_data=buffer[byte_idx], clear the watchdog counter, go to WAIT_DONE.
  - Latency: start in cycle N gives tx_start in cycle N+1.
- WAIT_DONE:
  - tx_data is held stable.
  - On tx_done: if byte_idx is the last byte, go to DONE. Otherwise increment byte_idx and go to GAP if GAP_CYCLES>0, else to SEND.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC with no tx_done, pulse timeout_err, go to IDLE, and clear byte_idx.
- GAP: count GAP_CYCLES cycles, then go to SEND.
- DONE: frame_done=1 for one cycle, then go to IDLE. busy falls the cycle after DONE.
- tx_done arriving outside WAIT_DONE is ignored, with no count change.
- tx_done and watchdog expiry in the same cycle: tx_done wins.
- Back-to-back frames: a start in the IDLE cycle directly after DONE is accepted. Minimum frame-to-frame gap is 2 cycles.
- Counters saturate and never wrap within a frame. byte_idx width covers NBYTES+2 so the CRC option fits.

Optional Feature:
- Macro UART_FRAME_CRC_EN.
- When defined:
  - Computes CRC-16/CCITT-FALSE (polynomial 0x1021, init 0xFFFF, no reflection, no xorout) over the payload bytes as each is issued in SEND.
  - Appends two extra bytes, CRC[15:8] then CRC[7:0], so the frame is NBYTES+2 bytes.
  - CRC is re-initialised on frame capture and on reset.
  - DATA_W must be 8; elaboration errors otherwise.
- When not defined: exactly NBYTES bytes are sent, and no CRC logic is instantiated.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum;
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF;
  - a bytes-per-frame helper function that returns NBYTES, plus 2 when the CRC option is on.
- Sub-module crc16_byte: combinational single-byte CRC-16 update, used only under UART_FRAME_CRC_EN.

Test Plan:
- Byte ordering: NBYTES=4, frame_data=32'hDDCCBBAA, tx_done 10 cycles after each tx_start -> tx_data sequence AA, BB, CC, DD; exactly 4 tx_start pulses; frame_done one cycle after the 4th tx_done.
- Gap and start latency: GAP_CYCLES=3 -> tx_start comes exactly 4 cycles after each tx_done. start in cycle 0 -> first tx_start in cycle 1.
- Watchdog: TIMEOUT_CYC=16, tx_done withheld on byte 2 -> timeout_err pulses 16 cycles after that tx_start, busy=0 next cycle, and no frame_done.
- Reset and start rules: reset asserted while byte 1 is in WAIT_DONE -> all outputs 0 next cycle. start pulsed during busy -> ignored, no second frame.
- CRC option: UART_FRAME_CRC_EN, NBYTES=9, payload ASCII "123456789" -> 11 bytes sent, the last two 0x29 then 0xB1.
- Spurious handshake and back-to-back frames: tx_done asserted in IDLE and GAP -> no state or byte_idx change. Two back-to-back frames -> second frame data is correct.
